// File: rtl/dcache_pkg.sv
// dcache_pkg: geometry, state encoding and address field helpers shared by the
// data cache responder and its tag array.
package dcache_pkg;

    localparam int NUM_LINES   = 64;
    localparam int BLOCK_WORDS = 8;

    localparam int WORD_W   = $clog2(BLOCK_WORDS);
    localparam int OFFSET_W = WORD_W + 1;
    localparam int INDEX_W  = $clog2(NUM_LINES);
    localparam int TAG_W    = 16 - OFFSET_W - INDEX_W;
    localparam int CNT_W    = WORD_W + 1;

    // Byte-offset bits of an address within one line.
    localparam logic [15:0] OFFSET_MASK = 16'((1 << OFFSET_W) - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_e;

    function automatic logic [TAG_W-1:0] get_tag(input logic [15:0] addr);
        return addr[15 -: TAG_W];
    endfunction

    function automatic logic [INDEX_W-1:0] get_index(input logic [15:0] addr);
        return addr[OFFSET_W +: INDEX_W];
    endfunction

    // Word offset within the line; byte bit 0 is ignored.
    function automatic logic [WORD_W-1:0] get_word(input logic [15:0] addr);
        return addr[1 +: WORD_W];
    endfunction

endpackage

// File: rtl/dcache_responder_if.sv
// dcache_responder_if: memory-stage request/response bus plus the backing
// memory port. The cache sits on the slave modport.
interface dcache_responder_if;

    logic        cpu_en;
    logic        cpu_wr;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic [15:0] cpu_rdata;
    logic        stall;
    logic        mem_req;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;

    modport slave (
        input  cpu_en, cpu_wr, cpu_addr, cpu_wdata, mem_rvalid, mem_rdata,
        output cpu_rdata, stall, mem_req, mem_wr, mem_addr, mem_wdata
    );

    modport master (
        output cpu_en, cpu_wr, cpu_addr, cpu_wdata, mem_rvalid, mem_rdata,
        input  cpu_rdata, stall, mem_req, mem_wr, mem_addr, mem_wdata
    );

endinterface

// File: rtl/dcache_tag_array.sv
// dcache_tag_array: valid bit and tag per line. Combinational lookup,
// single synchronous write port, all lines invalidated by rst.
module dcache_tag_array
    import dcache_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] rd_index,
    input  logic [TAG_W-1:0]   rd_tag,
    output logic               hit,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic               wr_valid,
    input  logic [TAG_W-1:0]   wr_tag
);

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] valid_d;
    logic [TAG_W-1:0]     tag_q [NUM_LINES];

    // Next valid vector: apply the single write port.
    always_comb begin
        valid_d = valid_q;
        if (wr_en) begin
            valid_d[wr_index] = wr_valid;
        end else begin
            valid_d = valid_q;
        end
    end

    // Valid bits clear on reset so every line starts cold.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag storage needs no reset; a tag is only trusted behind its valid bit.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_index] <= wr_tag;
        end
    end

    // Lookup for the request currently presented.
    always_comb begin
        hit = valid_q[rd_index] && (tag_q[rd_index] == rd_tag);
    end

endmodule

// File: rtl/dcache_responder.sv
// dcache_responder: direct-mapped, write-through, no-write-allocate data cache
// for the memory stage. Load misses stall the pipeline while the line is
// streamed in from a pipelined backing memory.
// Optional build macro: DCACHE_STATS_EN adds saturating hit_cnt / miss_cnt.
module dcache_responder
    import dcache_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
`ifdef DCACHE_STATS_EN
    output logic [15:0]        hit_cnt,
    output logic [15:0]        miss_cnt,
`endif
    dcache_responder_if.slave  bus
);

    localparam logic [0:0] S_IDLE = IDLE;
    localparam logic [0:0] S_FILL = FILL;

    logic [0:0]       state_q, state_d;
    logic [15:0]      base_q, base_d;
    logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;
    logic [WORD_W-1:0] recv_cnt_q, recv_cnt_d;

    logic [15:0] data_mem_q [NUM_LINES*BLOCK_WORDS];
    logic        data_we_s;
    logic [INDEX_W+WORD_W-1:0] data_widx_s;
    logic [15:0] data_wval_s;

    logic               hit_s;
    logic               tag_we_s;
    logic [INDEX_W-1:0] tag_widx_s;
    logic               tag_wvalid_s;
    logic [TAG_W-1:0]   tag_wtag_s;

    logic [TAG_W-1:0]   cpu_tag_s;
    logic [INDEX_W-1:0] cpu_index_s;
    logic [WORD_W-1:0]  cpu_word_s;
    logic               load_hit_s;
    logic               fill_start_s;

    // Split the request address into cache fields.
    always_comb begin
        cpu_tag_s   = get_tag(bus.cpu_addr);
        cpu_index_s = get_index(bus.cpu_addr);
        cpu_word_s  = get_word(bus.cpu_addr);
    end

    dcache_tag_array u_tags (
        .clk      (clk),
        .rst      (rst),
        .rd_index (cpu_index_s),
        .rd_tag   (cpu_tag_s),
        .hit      (hit_s),
        .wr_en    (tag_we_s),
        .wr_index (tag_widx_s),
        .wr_valid (tag_wvalid_s),
        .wr_tag   (tag_wtag_s)
    );

    // Control: request decode in IDLE, line streaming in FILL, outputs held low in reset.
    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        issue_cnt_d  = issue_cnt_q;
        recv_cnt_d   = recv_cnt_q;
        bus.cpu_rdata = 16'h0000;
        bus.stall     = 1'b0;
        bus.mem_req   = 1'b0;
        bus.mem_wr    = 1'b0;
        bus.mem_addr  = 16'h0000;
        bus.mem_wdata = 16'h0000;
        data_we_s    = 1'b0;
        data_widx_s  = {cpu_index_s, cpu_word_s};
        data_wval_s  = bus.cpu_wdata;
        tag_we_s     = 1'b0;
        tag_widx_s   = cpu_index_s;
        tag_wvalid_s = 1'b0;
        tag_wtag_s   = cpu_tag_s;
        load_hit_s   = 1'b0;
        fill_start_s = 1'b0;
        if (rst) begin
            state_d     = S_IDLE;
            base_d      = 16'h0000;
            issue_cnt_d = '0;
            recv_cnt_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.cpu_en) begin
                        if (bus.cpu_wr) begin
                            // Write-through; only a resident line is updated.
                            bus.mem_req   = 1'b1;
                            bus.mem_wr    = 1'b1;
                            bus.mem_addr  = bus.cpu_addr & 16'hFFFE;
                            bus.mem_wdata = bus.cpu_wdata;
                            data_we_s     = hit_s;
                        end else if (hit_s) begin
                            bus.cpu_rdata = data_mem_q[{cpu_index_s, cpu_word_s}];
                            load_hit_s    = 1'b1;
                        end else begin
                            // Line is invalid until the whole block has arrived.
                            bus.stall    = 1'b1;
                            state_d      = S_FILL;
                            base_d       = bus.cpu_addr & ~OFFSET_MASK;
                            issue_cnt_d  = '0;
                            recv_cnt_d   = '0;
                            tag_we_s     = 1'b1;
                            tag_wvalid_s = 1'b0;
                            fill_start_s = 1'b1;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_FILL: begin
                    bus.stall = 1'b1;
                    if (issue_cnt_q < CNT_W'(BLOCK_WORDS)) begin
                        bus.mem_req  = 1'b1;
                        bus.mem_addr = base_q + {{(15-CNT_W){1'b0}}, issue_cnt_q, 1'b0};
                        issue_cnt_d  = issue_cnt_q + CNT_W'(1);
                    end else begin
                        issue_cnt_d = issue_cnt_q;
                    end
                    if (bus.mem_rvalid) begin
                        data_we_s   = 1'b1;
                        data_widx_s = {get_index(base_q), recv_cnt_q};
                        data_wval_s = bus.mem_rdata;
                        recv_cnt_d  = recv_cnt_q + WORD_W'(1);
                        if (recv_cnt_q == WORD_W'(BLOCK_WORDS - 1)) begin
                            tag_we_s     = 1'b1;
                            tag_widx_s   = get_index(base_q);
                            tag_wvalid_s = 1'b1;
                            tag_wtag_s   = get_tag(base_q);
                            state_d      = S_IDLE;
                        end else begin
                            state_d = S_FILL;
                        end
                    end else begin
                        recv_cnt_d = recv_cnt_q;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            base_q      <= 16'h0000;
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
        end
    end

    // Data array write port: store hits and fill beats.
    always_ff @(posedge clk) begin
        if (data_we_s) begin
            data_mem_q[data_widx_s] <= data_wval_s;
        end
    end

`ifdef DCACHE_STATS_EN
    logic [15:0] hit_cnt_q, hit_cnt_d;
    logic [15:0] miss_cnt_q, miss_cnt_d;

    // Saturating event counters.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (load_hit_s && (hit_cnt_q != 16'hFFFF)) begin
            hit_cnt_d = hit_cnt_q + 16'd1;
        end else begin
            hit_cnt_d = hit_cnt_q;
        end
        if (fill_start_s && (miss_cnt_q != 16'hFFFF)) begin
            miss_cnt_d = miss_cnt_q + 16'd1;
        end else begin
            miss_cnt_d = miss_cnt_q;
        end
    end

    // Counter registers, cleared on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= 16'h0000;
            miss_cnt_q <= 16'h0000;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_responder.sv
// tb_dcache_responder: directed tests of the data cache responder against a
// 4-cycle-latency pipelined memory that returns each word equal to its address.
module tb_dcache_responder;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad = 0;

    dcache_responder_if bus_if ();

`ifdef DCACHE_STATS_EN
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;
`endif

    dcache_responder dut (
        .clk      (clk),
        .rst      (rst),
`ifdef DCACHE_STATS_EN
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt),
`endif
        .bus      (bus_if)
    );

    always #5 clk = ~clk;

    // Backing memory: read request accepted in cycle c returns in cycle c+4.
    logic [3:0]  pv = 4'b0000;
    logic [15:0] pa [4];
    always @(posedge clk) begin
        pv    <= {pv[2:0], bus_if.mem_req & ~bus_if.mem_wr};
        pa[0] <= bus_if.mem_addr;
        pa[1] <= pa[0];
        pa[2] <= pa[1];
        pa[3] <= pa[2];
    end
    assign bus_if.mem_rvalid = pv[3];
    assign bus_if.mem_rdata  = pa[3];

    // Hold a load until stall drops; report stall cycles and read requests seen.
    task automatic do_load(input logic [15:0] addr, output int stall_cyc, output int nreq,
                           output logic [15:0] first_a, output logic [15:0] last_a,
                           output bit seq_ok, output logic [15:0] rdata, output bit timed_out);
        bit done;
        bus_if.cpu_en = 1'b1; bus_if.cpu_wr = 1'b0; bus_if.cpu_addr = addr; bus_if.cpu_wdata = 16'h0000;
        stall_cyc = 0; nreq = 0; first_a = 16'h0000; last_a = 16'h0000;
        seq_ok = 1'b1; rdata = 16'h0000; timed_out = 1'b1; done = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            if (bus_if.mem_req && !bus_if.mem_wr) begin
                if (nreq == 0) first_a = bus_if.mem_addr;
                else if (bus_if.mem_addr != last_a + 16'd2) seq_ok = 1'b0;
                last_a = bus_if.mem_addr;
                nreq++;
            end
            if (!bus_if.stall) begin
                rdata = bus_if.cpu_rdata; timed_out = 1'b0; done = 1'b1;
            end else begin
                stall_cyc++;
            end
            @(posedge clk); #1;
        end
    endtask

    // One-cycle store; reports the memory-side write observed.
    task automatic do_store(input logic [15:0] addr, input logic [15:0] data,
                            output logic req, output logic wr, output logic [15:0] maddr,
                            output logic [15:0] mdata, output logic st);
        bus_if.cpu_en = 1'b1; bus_if.cpu_wr = 1'b1; bus_if.cpu_addr = addr; bus_if.cpu_wdata = data;
        @(negedge clk);
        req = bus_if.mem_req; wr = bus_if.mem_wr; maddr = bus_if.mem_addr;
        mdata = bus_if.mem_wdata; st = bus_if.stall;
        @(posedge clk); #1;
    endtask

    int st, nr;
    logic [15:0] fa, la, rd, ma, md;
    bit sq, to;
    logic rq, wq, sl;

    task automatic test_reset();
        rst = 1'b1;
        bus_if.cpu_en = 1'b1; bus_if.cpu_wr = 1'b1; bus_if.cpu_addr = 16'h1235; bus_if.cpu_wdata = 16'hAAAA;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (bus_if.stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b exp=0", bus_if.stall); end
        total++; if (bus_if.mem_req !== 1'b0) begin bad++; $display("FAIL rst_mem_req got=%b exp=0", bus_if.mem_req); end
        total++; if (bus_if.mem_wr !== 1'b0) begin bad++; $display("FAIL rst_mem_wr got=%b exp=0", bus_if.mem_wr); end
        total++; if (bus_if.mem_addr !== 16'h0000) begin bad++; $display("FAIL rst_mem_addr got=%h exp=0000", bus_if.mem_addr); end
        total++; if (bus_if.mem_wdata !== 16'h0000) begin bad++; $display("FAIL rst_mem_wdata got=%h exp=0000", bus_if.mem_wdata); end
        total++; if (bus_if.cpu_rdata !== 16'h0000) begin bad++; $display("FAIL rst_cpu_rdata got=%h exp=0000", bus_if.cpu_rdata); end
`ifdef DCACHE_STATS_EN
        total++; if (hit_cnt !== 16'h0000 || miss_cnt !== 16'h0000) begin bad++; $display("FAIL rst_stats got=%h/%h exp=0000/0000", hit_cnt, miss_cnt); end
`endif
        @(posedge clk); #1;
        rst = 1'b0; bus_if.cpu_en = 1'b0;
        @(negedge clk);
        total++; if (bus_if.stall !== 1'b0 || bus_if.mem_req !== 1'b0) begin bad++; $display("FAIL idle_no_en got stall=%b req=%b exp=0/0", bus_if.stall, bus_if.mem_req); end
        @(posedge clk); #1;
    endtask

    task automatic test_cold_load();
        do_load(16'h0024, st, nr, fa, la, sq, rd, to);
        total++; if (to) begin bad++; $display("FAIL cold_timeout got=timeout exp=done"); end
        total++; if (st != 13) begin bad++; $display("FAIL cold_stall got=%0d exp=13", st); end
        total++; if (nr != 8) begin bad++; $display("FAIL cold_nreq got=%0d exp=8", nr); end
        total++; if (fa !== 16'h0020 || la !== 16'h002E || !sq) begin bad++; $display("FAIL cold_addrs got=%h..%h seq=%b exp=0020..002E seq=1", fa, la, sq); end
        total++; if (rd !== 16'h0024) begin bad++; $display("FAIL cold_rdata got=%h exp=0024", rd); end
    endtask

    task automatic test_spatial_hit();
        do_load(16'h002A, st, nr, fa, la, sq, rd, to);
        total++; if (st != 0 || nr != 0) begin bad++; $display("FAIL spatial_nostall got stall=%0d req=%0d exp=0/0", st, nr); end
        total++; if (rd !== 16'h002A) begin bad++; $display("FAIL spatial_rdata got=%h exp=002A", rd); end
    endtask

    task automatic test_store_hit();
        do_store(16'h0022, 16'hBEEF, rq, wq, ma, md, sl);
        total++; if (rq !== 1'b1 || wq !== 1'b1 || sl !== 1'b0) begin bad++; $display("FAIL sthit_ctl got req=%b wr=%b stall=%b exp=1/1/0", rq, wq, sl); end
        total++; if (ma !== 16'h0022 || md !== 16'hBEEF) begin bad++; $display("FAIL sthit_bus got=%h/%h exp=0022/BEEF", ma, md); end
        do_load(16'h0022, st, nr, fa, la, sq, rd, to);
        total++; if (st != 0 || rd !== 16'hBEEF) begin bad++; $display("FAIL sthit_load got stall=%0d data=%h exp=0/BEEF", st, rd); end
        // Odd byte address: the write goes to the containing word.
        do_store(16'h0027, 16'h1234, rq, wq, ma, md, sl);
        total++; if (ma !== 16'h0026 || md !== 16'h1234) begin bad++; $display("FAIL stodd_bus got=%h/%h exp=0026/1234", ma, md); end
        do_load(16'h0026, st, nr, fa, la, sq, rd, to);
        total++; if (st != 0 || rd !== 16'h1234) begin bad++; $display("FAIL stodd_load got stall=%0d data=%h exp=0/1234", st, rd); end
    endtask

    task automatic test_store_miss();
        do_store(16'h0420, 16'h5555, rq, wq, ma, md, sl);
        total++; if (rq !== 1'b1 || wq !== 1'b1 || sl !== 1'b0 || ma !== 16'h0420 || md !== 16'h5555) begin
            bad++; $display("FAIL stmiss_bus got req=%b wr=%b stall=%b %h/%h exp=1/1/0 0420/5555", rq, wq, sl, ma, md);
        end
        do_load(16'h0020, st, nr, fa, la, sq, rd, to);
        total++; if (st != 0 || nr != 0 || rd !== 16'h0020) begin bad++; $display("FAIL stmiss_noalloc got stall=%0d req=%0d data=%h exp=0/0/0020", st, nr, rd); end
    endtask

    task automatic test_conflict();
        do_load(16'h0420, st, nr, fa, la, sq, rd, to);
        total++; if (st != 13 || nr != 8 || fa !== 16'h0420 || rd !== 16'h0420) begin
            bad++; $display("FAIL conflict_fill got stall=%0d req=%0d first=%h data=%h exp=13/8/0420/0420", st, nr, fa, rd);
        end
        do_load(16'h0020, st, nr, fa, la, sq, rd, to);
        total++; if (st != 13 || rd !== 16'h0020) begin bad++; $display("FAIL conflict_evict got stall=%0d data=%h exp=13/0020", st, rd); end
    endtask

    task automatic test_back_to_back();
        do_load(16'h002C, st, nr, fa, la, sq, rd, to);
        total++; if (st != 0 || rd !== 16'h002C) begin bad++; $display("FAIL b2b_load1 got stall=%0d data=%h exp=0/002C", st, rd); end
        do_store(16'h002E, 16'h7777, rq, wq, ma, md, sl);
        total++; if (rq !== 1'b1 || sl !== 1'b0 || ma !== 16'h002E) begin bad++; $display("FAIL b2b_store got req=%b stall=%b addr=%h exp=1/0/002E", rq, sl, ma); end
        do_load(16'h002E, st, nr, fa, la, sq, rd, to);
        total++; if (st != 0 || rd !== 16'h7777) begin bad++; $display("FAIL b2b_load2 got stall=%0d data=%h exp=0/7777", st, rd); end
        do_load(16'h0020, st, nr, fa, la, sq, rd, to);
        total++; if (st != 0 || rd !== 16'h0020) begin bad++; $display("FAIL b2b_load3 got stall=%0d data=%h exp=0/0020", st, rd); end
    endtask

    task automatic test_reset_mid_fill();
        int  nrv;
        bit  done;
        bit  noisy;
        nrv = 0; done = 1'b0; noisy = 1'b0;
        bus_if.cpu_en = 1'b1; bus_if.cpu_wr = 1'b0; bus_if.cpu_addr = 16'h0064;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (bus_if.mem_rvalid) nrv++;
            if (nrv == 3) done = 1'b1;
            @(posedge clk); #1;
        end
        total++; if (!done) begin bad++; $display("FAIL midrst_timeout got rvalids=%0d exp=3", nrv); end
        rst = 1'b1;
        @(negedge clk);
        total++; if (bus_if.stall !== 1'b0 || bus_if.mem_req !== 1'b0) begin bad++; $display("FAIL midrst_outputs got stall=%b req=%b exp=0/0", bus_if.stall, bus_if.mem_req); end
        @(posedge clk); #1;
        rst = 1'b0; bus_if.cpu_en = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus_if.stall !== 1'b0 || bus_if.mem_req !== 1'b0) noisy = 1'b1;
            @(posedge clk); #1;
        end
        total++; if (noisy) begin bad++; $display("FAIL midrst_quiet got=activity exp=idle"); end
        do_load(16'h0064, st, nr, fa, la, sq, rd, to);
        total++; if (st != 13 || nr != 8 || fa !== 16'h0060 || rd !== 16'h0064) begin
            bad++; $display("FAIL midrst_refill got stall=%0d req=%0d first=%h data=%h exp=13/8/0060/0064", st, nr, fa, rd);
        end
    endtask

    task automatic test_wrap();
        do_load(16'hFFF6, st, nr, fa, la, sq, rd, to);
        total++; if (st != 13 || fa !== 16'hFFF0 || la !== 16'hFFFE || !sq || rd !== 16'hFFF6) begin
            bad++; $display("FAIL wrap_fill got stall=%0d %h..%h seq=%b data=%h exp=13 FFF0..FFFE 1 FFF6", st, fa, la, sq, rd);
        end
        do_load(16'hFFFE, st, nr, fa, la, sq, rd, to);
        total++; if (st != 0 || rd !== 16'hFFFE) begin bad++; $display("FAIL wrap_hit got stall=%0d data=%h exp=0/FFFE", st, rd); end
        bus_if.cpu_en = 1'b0;
        @(posedge clk); #1;
`ifdef DCACHE_STATS_EN
        total++; if (hit_cnt !== 16'd3 || miss_cnt !== 16'd2) begin bad++; $display("FAIL stats got hit=%0d miss=%0d exp=3/2", hit_cnt, miss_cnt); end
`endif
    endtask

    initial begin
        rst = 1'b1;
        bus_if.cpu_en = 1'b0; bus_if.cpu_wr = 1'b0; bus_if.cpu_addr = 16'h0000; bus_if.cpu_wdata = 16'h0000;
        test_reset();
        test_cold_load();
        test_spatial_hit();
        test_store_hit();
        test_store_miss();
        test_conflict();
        test_back_to_back();
        test_reset_mid_fill();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
